// File: rtl/debug_pkg.sv
`timescale 1ns/1ps
// debug_pkg
// Shared types and defaults for the end-of-run debug dump path.
//   state_t   : dump sequencer / serializer FSM states
//   section_t : which source the current dumped word comes from
//   BYTES_PER_WORD : UART bytes per dumped word at the default widths
package debug_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    LATCH,
    SEND,
    WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SEC_PC,
    SEC_COUNT,
    SEC_REGS,
    SEC_MEM
  } section_t;

  localparam int DEFAULT_BITS_SIZE  = 32;
  localparam int DEFAULT_SIZE_TRAMA = 8;
  localparam int BYTES_PER_WORD     = DEFAULT_BITS_SIZE / DEFAULT_SIZE_TRAMA;

endpackage

// File: rtl/debug_word_serializer.sv
`timescale 1ns/1ps
// debug_word_serializer
// Captures one word and hands it to the UART transmitter LSB-first, one
// byte per tx handshake.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture `word` and start sending (only accepted when idle)
//   word       : word to serialize
//   tx_done    : UART finished current byte (honoured only while waiting)
//   tx_data    : current byte (low slice of the shift register)
//   tx_start   : one-cycle pulse asking the UART to latch tx_data
//   busy       : a word is being sent
//   word_done  : combinational pulse on the tx_done that completes the word
module debug_word_serializer
  import debug_pkg::*;
#(
  parameter int BITS_SIZE  = DEFAULT_BITS_SIZE,
  parameter int SIZE_TRAMA = DEFAULT_SIZE_TRAMA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BITS_SIZE-1:0]  word,
  input  logic                  tx_done,
  output logic [SIZE_TRAMA-1:0] tx_data,
  output logic                  tx_start,
  output logic                  busy,
  output logic                  word_done
);

  localparam int BPW   = BITS_SIZE / SIZE_TRAMA;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BPW - 1);

  // Only IDLE, SEND and WAIT are used here.
  state_t               phase, phase_next;
  logic [BITS_SIZE-1:0] shreg;
  logic [CNT_W-1:0]     byte_cnt;
  logic                 last_byte;

  assign last_byte = (byte_cnt == LAST_BYTE);

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    phase_next = phase;
    word_done  = 1'b0;
    unique case (phase)
      IDLE: if (load) phase_next = SEND;
      SEND: phase_next = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (last_byte) begin
            word_done  = 1'b1;
            phase_next = IDLE;
          end else begin
            phase_next = SEND;
          end
        end
      end
      default: phase_next = IDLE;
    endcase
  end

  // NOTE: the shift register is reset too (it is not a RAM), so tx_data
  // reads zero out of reset and after an aborted dump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= IDLE;
      shreg    <= '0;
      byte_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // the pre-edge values regardless of statement order.
      phase <= phase_next;
      if (load && phase == IDLE) begin
        shreg    <= word;
        byte_cnt <= '0;
      end else if (phase == WAIT && tx_done) begin
        shreg    <= shreg >> SIZE_TRAMA;
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
    end
  end

  assign tx_data  = shreg[SIZE_TRAMA-1:0];
  assign tx_start = (phase == SEND);
  assign busy     = (phase != IDLE);

endmodule

// File: rtl/debug_dump_sequencer.sv
`timescale 1ns/1ps
// debug_dump_sequencer
// Walks PC, cycle count, the register file and a data-memory window,
// reading each word through the MIPS select ports and streaming it to the
// shared UART transmitter LSB-first.
// Ports:
//   i_clk, i_reset        : clock, asynchronous active-high reset
//   i_start               : one-cycle dump request (ignored unless idle)
//   i_tx_done             : UART byte-finished pulse
//   i_pc, i_clk_count     : PC and cycle count words
//   i_data_reg_file       : register read data for o_select_register_dir
//   i_data_mem            : memory read data for o_select_mem_dir
//   o_select_register_dir : register index being read
//   o_select_mem_dir      : data-memory word index being read
//   o_tx_data, o_tx_start : UART byte and its one-cycle start strobe
//   o_busy                : dump in progress
//   o_done                : one-cycle pulse after the final byte
module debug_dump_sequencer
  import debug_pkg::*;
#(
  parameter  int BITS_SIZE     = DEFAULT_BITS_SIZE,
  parameter  int SIZE_TRAMA    = DEFAULT_SIZE_TRAMA,
  parameter  int NUM_REGS      = 32,
  parameter  int NUM_MEM_WORDS = 32,
  localparam int REG_SEL_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_tx_done,
  input  logic [BITS_SIZE-1:0]  i_pc,
  input  logic [BITS_SIZE-1:0]  i_clk_count,
  input  logic [BITS_SIZE-1:0]  i_data_reg_file,
  input  logic [BITS_SIZE-1:0]  i_data_mem,
  output logic [REG_SEL_W-1:0]  o_select_register_dir,
  output logic [BITS_SIZE-1:0]  o_select_mem_dir,
  output logic [SIZE_TRAMA-1:0] o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_busy,
  output logic                  o_done
);

  // Only meaningful when the matching section is non-empty.
  localparam logic [BITS_SIZE-1:0] LAST_REG = BITS_SIZE'(NUM_REGS - 1);
  localparam logic [BITS_SIZE-1:0] LAST_MEM = BITS_SIZE'(NUM_MEM_WORDS - 1);

  state_t               state, state_next;
  section_t             sec, adv_sec;
  logic [BITS_SIZE-1:0] idx, adv_idx;
  logic                 adv_valid;
  logic [BITS_SIZE-1:0] word_src;
  logic                 load_word;
  logic                 ser_busy;
  logic                 word_done;

  // Which word follows the current one; empty sections are skipped.
  always_comb begin
    adv_valid = 1'b0;
    adv_sec   = sec;
    adv_idx   = idx;
    unique case (sec)
      SEC_PC: begin
        adv_valid = 1'b1;
        adv_sec   = SEC_COUNT;
        adv_idx   = '0;
      end
      SEC_COUNT: begin
        if (NUM_REGS > 0) begin
          adv_valid = 1'b1;
          adv_sec   = SEC_REGS;
          adv_idx   = '0;
        end else if (NUM_MEM_WORDS > 0) begin
          adv_valid = 1'b1;
          adv_sec   = SEC_MEM;
          adv_idx   = '0;
        end
      end
      SEC_REGS: begin
        if (idx != LAST_REG) begin
          adv_valid = 1'b1;
          adv_idx   = idx + BITS_SIZE'(1);
        end else if (NUM_MEM_WORDS > 0) begin
          adv_valid = 1'b1;
          adv_sec   = SEC_MEM;
          adv_idx   = '0;
        end
      end
      SEC_MEM: begin
        if (idx != LAST_MEM) begin
          adv_valid = 1'b1;
          adv_idx   = idx + BITS_SIZE'(1);
        end
      end
      default: adv_valid = 1'b0;
    endcase
  end

  always_comb begin
    word_src = i_pc;
    unique case (sec)
      SEC_PC:    word_src = i_pc;
      SEC_COUNT: word_src = i_clk_count;
      SEC_REGS:  word_src = i_data_reg_file;
      SEC_MEM:   word_src = i_data_mem;
      default:   word_src = i_pc;
    endcase
  end

  // SEND/WAIT here track the serializer's handshake cycle for cycle.
  always_comb begin
    state_next = state;
    load_word  = 1'b0;
    unique case (state)
      IDLE:   if (i_start) state_next = SELECT;
      SELECT: state_next = LATCH;
      LATCH: begin
        load_word  = 1'b1;
        state_next = SEND;
      end
      SEND:   state_next = WAIT;
      WAIT: begin
        if (word_done)      state_next = adv_valid ? SELECT : DONE;
        else if (i_tx_done) state_next = SEND;
      end
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state                 <= IDLE;
      sec                   <= SEC_PC;
      idx                   <= '0;
      o_select_register_dir <= '0;
      o_select_mem_dir      <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && i_start) begin
        sec <= SEC_PC;
        idx <= '0;
      end else if (state == WAIT && word_done && adv_valid) begin
        // Selects change on entry to SELECT so the source has until the end
        // of LATCH to respond (combinational or one-cycle registered read).
        sec <= adv_sec;
        idx <= adv_idx;
        if (adv_sec == SEC_REGS) o_select_register_dir <= adv_idx[REG_SEL_W-1:0];
        if (adv_sec == SEC_MEM)  o_select_mem_dir      <= adv_idx;
      end
    end
  end

  debug_word_serializer #(
    .BITS_SIZE  (BITS_SIZE),
    .SIZE_TRAMA (SIZE_TRAMA)
  ) u_serializer (
    .clk       (i_clk),
    .rst       (i_reset),
    .load      (load_word),
    .word      (word_src),
    .tx_done   (i_tx_done),
    .tx_data   (o_tx_data),
    .tx_start  (o_tx_start),
    .busy      (ser_busy),
    .word_done (word_done)
  );

  assign o_busy = (state == SELECT) || (state == LATCH) || ser_busy;
  assign o_done = (state == DONE);

endmodule

// File: tb/tb_debug_dump_sequencer.sv
`timescale 1ns/1ps
// tb_debug_dump_sequencer
// Directed bench: default-size dump with disturbances, reset mid-dump and
// re-dump, plus a reduced instance with no registers and one memory word.
module tb_debug_dump_sequencer;
  import debug_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start = 1'b0;
  logic        uart_done = 1'b0;
  logic        spur_done = 1'b0;
  logic        tx_done;
  logic [31:0] pc = 32'h1234_5678;
  logic [31:0] clk_count = 32'h0000_00FF;
  logic [31:0] reg_data, mem_data;
  logic [4:0]  sel_reg;
  logic [31:0] sel_mem;
  logic [7:0]  tx_data;
  logic        tx_start, busy, done;

  assign tx_done  = uart_done | spur_done;
  assign reg_data = {27'd0, sel_reg} * 32'h0101_0101;
  assign mem_data = 32'hA000_0000 + sel_mem;

  debug_dump_sequencer dut (
    .i_clk                 (clk),
    .i_reset               (rst),
    .i_start               (start),
    .i_tx_done             (tx_done),
    .i_pc                  (pc),
    .i_clk_count           (clk_count),
    .i_data_reg_file       (reg_data),
    .i_data_mem            (mem_data),
    .o_select_register_dir (sel_reg),
    .o_select_mem_dir      (sel_mem),
    .o_tx_data             (tx_data),
    .o_tx_start            (tx_start),
    .o_busy                (busy),
    .o_done                (done)
  );

  // Reduced instance: no register section, one memory word.
  logic        start2 = 1'b0;
  logic        uart2_done = 1'b0;
  logic [0:0]  sel_reg2;
  logic [31:0] sel_mem2, mem_data2;
  logic [7:0]  tx_data2;
  logic        tx_start2, busy2, done2;

  assign mem_data2 = 32'hA000_0000 + sel_mem2;

  debug_dump_sequencer #(
    .NUM_REGS      (0),
    .NUM_MEM_WORDS (1)
  ) dut2 (
    .i_clk                 (clk),
    .i_reset               (rst),
    .i_start               (start2),
    .i_tx_done             (uart2_done),
    .i_pc                  (pc),
    .i_clk_count           (clk_count),
    .i_data_reg_file       (32'hBAD0_0000),
    .i_data_mem            (mem_data2),
    .o_select_register_dir (sel_reg2),
    .o_select_mem_dir      (sel_mem2),
    .o_tx_data             (tx_data2),
    .o_tx_start            (tx_start2),
    .o_busy                (busy2),
    .o_done                (done2)
  );

  // UART models: i_tx_done pulses 5 cycles after each o_tx_start cycle.
  always begin
    @(posedge clk);
    if (tx_start) begin
      repeat (4) @(posedge clk);
      #1 uart_done = 1'b1;
      @(posedge clk);
      #1 uart_done = 1'b0;
    end
  end

  always begin
    @(posedge clk);
    if (tx_start2) begin
      repeat (4) @(posedge clk);
      #1 uart2_done = 1'b1;
      @(posedge clk);
      #1 uart2_done = 1'b0;
    end
  end

  // Byte-stream monitors.
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int         sel_at_word[66];
  int         done1_cnt = 0;
  int         done2_cnt = 0;
  time        last_tx_done1 = 0;
  time        last_tx_done2 = 0;

  always @(posedge clk) begin
    if (tx_start) begin
      if ((q1.size() % BYTES_PER_WORD) == 0 && (q1.size() / BYTES_PER_WORD) < 66)
        sel_at_word[q1.size() / BYTES_PER_WORD] = int'(sel_reg);
      q1.push_back(tx_data);
    end
    if (tx_start2) q2.push_back(tx_data2);
    if (done)  done1_cnt++;
    if (done2) done2_cnt++;
    if (tx_done)    last_tx_done1 = $time;
    if (uart2_done) last_tx_done2 = $time;
  end

  function automatic logic [31:0] word1(input int w);
    logic [31:0] v = '0;
    for (int b = 0; b < BYTES_PER_WORD; b++)
      if (w * BYTES_PER_WORD + b < q1.size()) v[8*b +: 8] = q1[w * BYTES_PER_WORD + b];
    return v;
  endfunction

  function automatic logic [31:0] word2(input int w);
    logic [31:0] v = '0;
    for (int b = 0; b < BYTES_PER_WORD; b++)
      if (w * BYTES_PER_WORD + b < q2.size()) v[8*b +: 8] = q2[w * BYTES_PER_WORD + b];
    return v;
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic got;
  logic busy_at_done;
  time  gap;
  int   n_before;

  initial begin
    // ---- reset state ----
    rst = 1'b1;
    step(3);
    check("rst_tx_start", tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_sel_reg", sel_reg, 0);
    check("rst_sel_mem", sel_mem, 0);
    check("rst_tx_start2", tx_start2, 0);
    rst = 1'b0;
    step(2);

    // ---- spurious tx_done while idle ----
    spur_done = 1'b1;
    step;
    spur_done = 1'b0;
    step;
    check("idle_spur_tx_start", tx_start, 0);
    check("idle_spur_busy", busy, 0);

    // ---- full dump with start/tx_done disturbances ----
    q1.delete();
    done1_cnt = 0;
    start = 1'b1;
    step;
    start = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_tx_start", tx_start, 0);
    step;
    check("t2_tx_start", tx_start, 0);
    step;
    check("t3_tx_start", tx_start, 1);
    check("t3_tx_data", tx_data, 32'h78);

    got = 1'b0;
    busy_at_done = 1'b1;
    gap = 0;
    for (int c = 0; c < 4000 && !got; c++) begin
      if (c % 37 == 5) start = 1'b1;
      if (tx_start && (c % 3 == 0)) spur_done = 1'b1;
      step;
      start = 1'b0;
      spur_done = 1'b0;
      if (done) begin
        got = 1'b1;
        busy_at_done = busy;
        gap = $time - last_tx_done1;
      end
    end
    check("dump1_done_seen", got, 1);
    check("dump1_busy_at_done", busy_at_done, 0);
    check("dump1_done_latency", 32'(gap), 1);
    step(20);
    check("dump1_done_count", done1_cnt, 1);
    check("dump1_byte_count", q1.size(), 264);
    check("dump1_pc_word", word1(0), 32'h1234_5678);
    check("dump1_count_word", word1(1), 32'h0000_00FF);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("reg_word%0d", i), word1(2 + i), i * 32'h0101_0101);
      check($sformatf("reg_sel%0d", i), sel_at_word[2 + i], i);
    end
    for (int k = 0; k < 32; k++)
      check($sformatf("mem_word%0d", k), word1(34 + k), 32'hA000_0000 + k);
    check("dump1_sel_mem_final", sel_mem, 31);
    check("dump1_sel_reg_final", sel_reg, 31);
    check("dump1_idle_busy", busy, 0);

    // ---- reset during byte 100, then re-dump ----
    q1.delete();
    done1_cnt = 0;
    pc = 32'hCAFE_F00D;
    start = 1'b1;
    step;
    start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      step;
      if (q1.size() >= 101) got = 1'b1;
    end
    check("byte100_reached", got, 1);
    // Byte 100 is byte 0 of reg[23]; it must still be held while waiting.
    check("byte100_hold", tx_data, 32'h17);
    rst = 1'b1;
    #1;
    check("abort_tx_start", tx_start, 0);
    check("abort_busy", busy, 0);
    check("abort_tx_data", tx_data, 0);
    check("abort_sel_reg", sel_reg, 0);
    check("abort_sel_mem", sel_mem, 0);
    check("abort_done", done, 0);
    step(3);
    rst = 1'b0;
    n_before = q1.size();
    step(60);
    check("abort_no_tx_start", q1.size(), n_before);
    check("abort_done_count", done1_cnt, 0);

    q1.delete();
    start = 1'b1;
    step;
    start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 4000 && !got; c++) begin
      step;
      if (done) got = 1'b1;
    end
    check("redump_done_seen", got, 1);
    step(10);
    check("redump_byte_count", q1.size(), 264);
    check("redump_pc_word", word1(0), 32'hCAFE_F00D);
    check("redump_count_word", word1(1), 32'h0000_00FF);
    check("redump_last_word", word1(65), 32'hA000_001F);
    check("redump_done_count", done1_cnt, 1);

    // ---- reduced instance: PC, count, mem[0] only ----
    start2 = 1'b1;
    step;
    start2 = 1'b0;
    check("small_busy", busy2, 1);
    got = 1'b0;
    gap = 0;
    for (int c = 0; c < 500 && !got; c++) begin
      step;
      if (done2) begin
        got = 1'b1;
        gap = $time - last_tx_done2;
      end
    end
    check("small_done_seen", got, 1);
    check("small_done_latency", 32'(gap), 1);
    step(10);
    check("small_byte_count", q2.size(), 12);
    check("small_pc_word", word2(0), 32'hCAFE_F00D);
    check("small_count_word", word2(1), 32'h0000_00FF);
    check("small_mem_word", word2(2), 32'hA000_0000);
    check("small_done_count", done2_cnt, 1);
    check("small_sel_mem", sel_mem2, 0);
    check("small_sel_reg", sel_reg2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
